// File: rtl/prbs_tx_sequencer.sv
// PRBS transmit sequencer: waits for GT TX reset done, sends comma words for
// alignment, then streams PRBS words with optional single-bit error injection.
module prbs_tx_sequencer #(
    parameter int unsigned      size        = 32,
    parameter int unsigned      align_words = 64,
    parameter int unsigned      max_words   = 0,
    parameter logic [size-1:0]  idle_word   = size'(32'h000000BC),
    parameter logic [size/8-1:0] idle_k     = (size/8)'(4'b0001)
) (
    input  logic                  gtwiz_userclk_tx_usrclk2_in,
    input  logic                  gtwiz_reset_all_n_in,
    input  logic                  tx_done_in,
    input  logic                  start_in,
    input  logic                  stop_in,
    input  logic                  err_inject_in,
    input  logic [size-1:0]       prbs_data_in,
    output logic                  prbs_rst_out,
    output logic [size-1:0]       tx_data_out,
    output logic [size/8-1:0]     tx_ctrl_out,
    output logic                  busy_out,
    output logic [31:0]           word_count_out,
    output logic [15:0]           err_count_out
);

    localparam int unsigned KW  = size / 8;
    localparam int unsigned ACW = 16;
    localparam int unsigned WCW = 32;
    localparam int unsigned ECW = 16;

    typedef enum logic [1:0] {
        WAIT_TX = 2'd0,
        IDLE    = 2'd1,
        ALIGN   = 2'd2,
        RUN     = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ACW-1:0]     align_cnt_q, align_cnt_d;
    logic [WCW-1:0]     word_cnt_q, word_cnt_d;
    logic [ECW-1:0]     err_cnt_q, err_cnt_d;
    logic [size-1:0]    tx_data_q, tx_data_d;
    logic [KW-1:0]      tx_ctrl_q, tx_ctrl_d;
    logic               busy_q, busy_d;
    logic               prbs_rst_q, prbs_rst_d;
    logic               inj_q;
    logic               inj_edge_c;
    logic               flip_c;

    // A flip only happens on a RUN word that is actually counted (no stop, TX still up)
    assign inj_edge_c = err_inject_in & ~inj_q;
    assign flip_c     = (state_q == RUN) & tx_done_in & ~stop_in & inj_edge_c;

    // Next-state, counters and registered-output values
    always_comb begin
        state_d     = state_q;
        align_cnt_d = align_cnt_q;
        word_cnt_d  = word_cnt_q;
        err_cnt_d   = err_cnt_q;
        tx_data_d   = idle_word;
        tx_ctrl_d   = idle_k;

        if (state_q == RUN) begin
            tx_data_d = prbs_data_in ^ size'(flip_c);
            tx_ctrl_d = '0;
        end

        if (!tx_done_in) begin
            state_d = WAIT_TX;
        end else begin
            case (state_q)
                WAIT_TX: begin
                    state_d = IDLE;
                end
                IDLE: begin
                    if (start_in) begin
                        state_d     = ALIGN;
                        align_cnt_d = ACW'(align_words);
                        word_cnt_d  = '0;
                        err_cnt_d   = '0;
                    end
                end
                ALIGN: begin
                    if (stop_in) begin
                        state_d = IDLE;
                    end else if (align_cnt_q <= ACW'(1)) begin
                        state_d = RUN;
                    end else begin
                        align_cnt_d = align_cnt_q - ACW'(1);
                    end
                end
                RUN: begin
                    if (stop_in) begin
                        state_d = IDLE;
                    end else begin
                        if (word_cnt_q != '1) begin
                            word_cnt_d = word_cnt_q + WCW'(1);
                        end
                        if (flip_c && (err_cnt_q != '1)) begin
                            err_cnt_d = err_cnt_q + ECW'(1);
                        end
                        if ((max_words != 0) && (word_cnt_d == WCW'(max_words))) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = WAIT_TX;
                end
            endcase
        end

        busy_d     = (state_d == ALIGN) || (state_d == RUN);
        prbs_rst_d = (state_d != RUN);
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge gtwiz_userclk_tx_usrclk2_in) begin
        if (!gtwiz_reset_all_n_in) begin
            state_q     <= WAIT_TX;
            align_cnt_q <= '0;
            word_cnt_q  <= '0;
            err_cnt_q   <= '0;
            tx_data_q   <= idle_word;
            tx_ctrl_q   <= idle_k;
            busy_q      <= 1'b0;
            prbs_rst_q  <= 1'b1;
            inj_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            align_cnt_q <= align_cnt_d;
            word_cnt_q  <= word_cnt_d;
            err_cnt_q   <= err_cnt_d;
            tx_data_q   <= tx_data_d;
            tx_ctrl_q   <= tx_ctrl_d;
            busy_q      <= busy_d;
            prbs_rst_q  <= prbs_rst_d;
            inj_q       <= err_inject_in;
        end
    end

    assign prbs_rst_out   = prbs_rst_q;
    assign tx_data_out    = tx_data_q;
    assign tx_ctrl_out    = tx_ctrl_q;
    assign busy_out       = busy_q;
    assign word_count_out = word_cnt_q;
    assign err_count_out  = err_cnt_q;

endmodule

// File: tb/tb_prbs_tx_sequencer.sv
// Directed bench for prbs_tx_sequencer with align_words=4, max_words=10.
module tb_prbs_tx_sequencer;

    localparam logic [31:0] IDLE_W = 32'h000000BC;
    localparam logic [3:0]  IDLE_K = 4'b0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tx_done;
    logic        start;
    logic        stop;
    logic        inj;
    logic [31:0] prbs;
    logic        prbs_rst;
    logic [31:0] tx_data;
    logic [3:0]  tx_ctrl;
    logic        busy;
    logic [31:0] wc;
    logic [15:0] ec;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    prbs_tx_sequencer #(
        .size(32), .align_words(4), .max_words(10),
        .idle_word(32'h000000BC), .idle_k(4'b0001)
    ) dut (
        .gtwiz_userclk_tx_usrclk2_in(clk),
        .gtwiz_reset_all_n_in(rst_n),
        .tx_done_in(tx_done),
        .start_in(start),
        .stop_in(stop),
        .err_inject_in(inj),
        .prbs_data_in(prbs),
        .prbs_rst_out(prbs_rst),
        .tx_data_out(tx_data),
        .tx_ctrl_out(tx_ctrl),
        .busy_out(busy),
        .word_count_out(wc),
        .err_count_out(ec)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pat(input int run, input int i);
        return (32'h9E3779B9 * 32'(i + 1)) ^ (32'(run) << 20);
    endfunction

    // Start pulse, then four alignment cycles of idle words
    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("start_busy", 32'(busy), 32'd1);
        check_eq("start_wc_clr", wc, 32'd0);
        check_eq("start_ec_clr", 32'(ec), 32'd0);
        for (int k = 0; k < 4; k++) begin
            check_eq("align_rst", 32'(prbs_rst), 32'd1);
            tick();
            check_eq("align_data", tx_data, IDLE_W);
            check_eq("align_ctrl", 32'(tx_ctrl), 32'(IDLE_K));
        end
        check_eq("run_prbs_rst", 32'(prbs_rst), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; tx_done = 1'b1; start = 1'b0; stop = 1'b0; inj = 1'b0; prbs = '0;

        // Reset held 4 cycles, then IDLE
        repeat (4) tick();
        check_eq("rst_data", tx_data, IDLE_W);
        check_eq("rst_ctrl", 32'(tx_ctrl), 32'(IDLE_K));
        check_eq("rst_prbs_rst", 32'(prbs_rst), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (3) tick();
        check_eq("idle_data", tx_data, IDLE_W);
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_prbs_rst", 32'(prbs_rst), 32'd1);

        // Run 1: exactly max_words PRBS words, one-cycle latency
        start_run();
        for (int i = 0; i < 10; i++) begin
            prbs = pat(1, i);
            tick();
            check_eq("r1_data", tx_data, pat(1, i));
            check_eq("r1_ctrl", 32'(tx_ctrl), 32'd0);
            check_eq("r1_wc", wc, 32'(i + 1));
            check_eq("r1_busy", 32'(busy), (i < 9) ? 32'd1 : 32'd0);
        end
        prbs = 32'hDEADBEEF;
        tick();
        check_eq("r1_end_data", tx_data, IDLE_W);
        check_eq("r1_end_ctrl", 32'(tx_ctrl), 32'(IDLE_K));
        check_eq("r1_end_wc", wc, 32'd10);
        check_eq("r1_end_rst", 32'(prbs_rst), 32'd1);

        // Run 2: inject held 5 cycles flips exactly one word
        start_run();
        for (int i = 0; i < 10; i++) begin
            prbs = pat(2, i);
            inj = (i >= 2 && i < 7);
            tick();
            check_eq("r2_data", tx_data, pat(2, i) ^ ((i == 2) ? 32'd1 : 32'd0));
            check_eq("r2_ec", 32'(ec), (i >= 2) ? 32'd1 : 32'd0);
        end
        inj = 1'b0;
        check_eq("r2_wc", wc, 32'd10);

        // Run 3: inject risen before RUN is ignored; inject with stop gives no flip
        inj = 1'b1;
        start_run();
        prbs = pat(3, 0);
        tick();
        check_eq("r3_held_data", tx_data, pat(3, 0));
        check_eq("r3_held_ec", 32'(ec), 32'd0);
        inj = 1'b0;
        prbs = pat(3, 1);
        tick();
        check_eq("r3_wc", wc, 32'd2);
        inj = 1'b1; stop = 1'b1; prbs = pat(3, 2);
        tick();
        inj = 1'b0; stop = 1'b0;
        check_eq("r3_stop_data", tx_data, pat(3, 2));
        check_eq("r3_stop_ec", 32'(ec), 32'd0);
        check_eq("r3_stop_wc", wc, 32'd2);
        check_eq("r3_stop_busy", 32'(busy), 32'd0);
        tick();
        check_eq("r3_idle_data", tx_data, IDLE_W);

        // Run 4: tx_done drop mid-RUN freezes counters, no auto-restart
        start_run();
        for (int i = 0; i < 3; i++) begin
            prbs = pat(4, i);
            tick();
            check_eq("r4_data", tx_data, pat(4, i));
        end
        tx_done = 1'b0;
        prbs = pat(4, 3);
        tick();
        check_eq("r4_drop_rst", 32'(prbs_rst), 32'd1);
        check_eq("r4_drop_busy", 32'(busy), 32'd0);
        check_eq("r4_drop_wc", wc, 32'd3);
        tick();
        check_eq("r4_wait_data", tx_data, IDLE_W);
        check_eq("r4_wait_wc", wc, 32'd3);
        tx_done = 1'b1;
        repeat (4) tick();
        check_eq("r4_idle_busy", 32'(busy), 32'd0);
        check_eq("r4_idle_rst", 32'(prbs_rst), 32'd1);
        check_eq("r4_idle_wc", wc, 32'd3);
        check_eq("r4_idle_data", tx_data, IDLE_W);

        // Run 5: reset mid-RUN
        start_run();
        for (int i = 0; i < 2; i++) begin
            prbs = pat(5, i);
            tick();
        end
        check_eq("r5_wc", wc, 32'd2);
        rst_n = 1'b0;
        tick();
        check_eq("r5_rst_data", tx_data, IDLE_W);
        check_eq("r5_rst_ctrl", 32'(tx_ctrl), 32'(IDLE_K));
        check_eq("r5_rst_prbs_rst", 32'(prbs_rst), 32'd1);
        check_eq("r5_rst_busy", 32'(busy), 32'd0);
        check_eq("r5_rst_wc", wc, 32'd0);
        check_eq("r5_rst_ec", 32'(ec), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
